// File: rtl/tl_sensor.sv
// ============================================================================
// tl_sensor : per-street car queue counters with optional light-protocol checker
// Optional checker enabled by macro TL_SENSOR_CHECKER_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module tl_sensor #(
  parameter int QW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arr_a,
  input  logic          arr_b,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qb,
  output logic          ovf,
  output logic          viol,
  output logic [1:0]    viol_code
);

  localparam logic [1:0]    GREEN   = 2'b00;
  localparam logic [1:0]    YELLOW  = 2'b01;
  localparam logic [1:0]    ILLEGAL = 2'b10;
  localparam logic [1:0]    RED     = 2'b11;
  localparam logic [QW-1:0] QMAX    = '1;

  logic dep_a;
  logic dep_b;

  assign dep_a = (La == GREEN) && (qa != '0);
  assign dep_b = (Lb == GREEN) && (qb != '0);

  // An arrival and a departure in the same cycle cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qa  <= '0;
      qb  <= '0;
      ovf <= 1'b0;
    end else begin
      if (arr_a && !dep_a) begin
        if (qa == QMAX) ovf <= 1'b1;
        else            qa  <= qa + 1'b1;
      end else if (dep_a && !arr_a) begin
        qa <= qa - 1'b1;
      end
      if (arr_b && !dep_b) begin
        if (qb == QMAX) ovf <= 1'b1;
        else            qb  <= qb + 1'b1;
      end else if (dep_b && !arr_b) begin
        qb <= qb - 1'b1;
      end
    end
  end

  assign Ta = (qa != '0);
  assign Tb = (qb != '0);

`ifdef TL_SENSOR_CHECKER_EN
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MON  = 2'b01,
    ERR  = 2'b10
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] prev_a;
  logic [1:0] prev_b;
  logic [1:0] code_nx;

  // A light may hold its colour or advance one step around G -> Y -> R -> G.
  function automatic logic step_ok(input logic [1:0] cur, input logic [1:0] nxt);
    case (cur)
      GREEN:   step_ok = (nxt == GREEN)  || (nxt == YELLOW);
      YELLOW:  step_ok = (nxt == YELLOW) || (nxt == RED);
      RED:     step_ok = (nxt == RED)    || (nxt == GREEN);
      default: step_ok = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    code_nx  = 2'b00;
    case (state)
      IDLE: state_nx = MON;
      MON: begin
        if ((La == ILLEGAL) || (Lb == ILLEGAL))
          code_nx = 2'b11;
        else if ((La != RED) && (Lb != RED))
          code_nx = 2'b01;
        else if (!step_ok(prev_a, La) || !step_ok(prev_b, Lb))
          code_nx = 2'b10;
        if (code_nx != 2'b00) state_nx = ERR;
      end
      ERR:     state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      prev_a    <= 2'b00;
      prev_b    <= 2'b00;
      viol      <= 1'b0;
      viol_code <= 2'b00;
    end else begin
      state <= state_nx;
      if (state != ERR) begin
        prev_a <= La;
        prev_b <= Lb;
      end
      // Only the first violation is recorded; ERR never leaves until reset.
      if ((state == MON) && (code_nx != 2'b00)) begin
        viol      <= 1'b1;
        viol_code <= code_nx;
      end
    end
  end
`else
  assign viol      = 1'b0;
  assign viol_code = 2'b00;
`endif

endmodule

`default_nettype wire
